// File: rtl/uart_frame_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package  : uart_frame_pkg                                              |
// | Purpose  : Shared ASCII constants, state/slot encodings and the BCD    |
// |            digit-to-ASCII helper for the UART frame sequencer.         |
// | Revision : 1.0  initial parametrised release                           |
// +------------------------------------------------------------------------+
package uart_frame_pkg;

  localparam logic [7:0] c_ascii_zero  = 8'h30;
  localparam logic [7:0] c_ascii_colon = 8'h3A;
  localparam logic [7:0] c_ascii_dot   = 8'h2E;
  localparam logic [7:0] c_ascii_qmark = 8'h3F;
  localparam logic [7:0] c_ascii_cr    = 8'h0D;
  localparam logic [7:0] c_ascii_lf    = 8'h0A;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Byte slots of one channel record plus the frame trailer.
  typedef enum logic [3:0] {
    SLOT_TENS  = 4'd0,
    SLOT_ONES  = 4'd1,
    SLOT_COLON = 4'd2,
    SLOT_D3    = 4'd3,
    SLOT_DOT   = 4'd4,
    SLOT_D2    = 4'd5,
    SLOT_D1    = 4'd6,
    SLOT_D0    = 4'd7,
    SLOT_SEP   = 4'd8,
    SLOT_CR    = 4'd9,
    SLOT_LF    = 4'd10
  } slot_t;

  // Non-decimal nibbles are reported as '?' rather than as garbage characters.
  function automatic logic [7:0] bcd_to_ascii(input logic [3:0] digit);
    if (digit > 4'd9) return c_ascii_qmark;
    return c_ascii_zero + {4'h0, digit};
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_frame_sequencer_tick_gen.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : frame_tick_gen                                              |
// | Purpose  : Free-running frame period counter, 0..PERIOD_CLKS-1.        |
// | Ports    : clk    - system clock                                       |
// |            rst    - asynchronous active-low reset                      |
// |            o_tick - one-cycle pulse, high in the cycle after the wrap  |
// | Revision : 1.0  initial parametrised release                           |
// +------------------------------------------------------------------------+
module frame_tick_gen
  import uart_frame_pkg::*;
#(
  parameter int PERIOD_CLKS = 65_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic o_tick
);

  localparam int CNT_W = $clog2(PERIOD_CLKS);
  localparam logic [CNT_W-1:0] c_last = CNT_W'(PERIOD_CLKS - 1);

  logic [CNT_W-1:0] r_count;
  logic             r_tick;

  // The tick is registered so the sequencer samples it one edge after the
  // wrap, which is what gives the snapshot its one-cycle offset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_tick  <= (r_count == c_last);
      r_count <= (r_count == c_last) ? '0 : r_count + 1'b1;
    end
  end

  assign o_tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/uart_frame_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : uart_frame_sequencer                                        |
// | Purpose  : Periodically snapshots NCH 4-digit BCD readings and writes  |
// |            them byte by byte as one ASCII frame into the UART TX FIFO: |
// |            "TO:D.DDD" per enabled channel, SEP between, CR LF at end.  |
// | Ports    : clk        - 65 MHz system clock                            |
// |            rst        - asynchronous active-low reset                  |
// |            enable     - allow new frames to start                      |
// |            ch_mask    - per-channel include bits                       |
// |            bcd_in     - channel i at [16i+15:16i], digit3 MS nibble    |
// |            tx_full    - FIFO full, stalls the byte stream              |
// |            wr_uart    - byte write strobe                              |
// |            w_data     - registered current byte                        |
// |            busy       - frame in progress                              |
// |            frame_done - one-cycle pulse after LF is accepted           |
// | Revision : 1.0  initial parametrised release                           |
// +------------------------------------------------------------------------+
module uart_frame_sequencer
  import uart_frame_pkg::*;
#(
  parameter int         NCH         = 13,
  parameter int         PERIOD_CLKS = 65_000_000,
  parameter int         DP_POS      = 3,
  parameter logic [7:0] SEP         = 8'h3B
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [NCH-1:0]    ch_mask,
  input  logic [16*NCH-1:0] bcd_in,
  input  logic              tx_full,
  output logic              wr_uart,
  output logic [7:0]        w_data,
  output logic              busy,
  output logic              frame_done
);

  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  state_t               r_state;
  slot_t                r_slot;
  logic [CH_W-1:0]      r_ch;
  logic [3:0]           r_tens;
  logic [3:0]           r_ones;
  logic [NCH-1:0][15:0] r_snap_bcd;
  logic [NCH-1:0]       r_snap_mask;
  logic [7:0]           r_data;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_tick;
  logic                 w_nxt_found;
  logic [CH_W-1:0]      w_nxt_ch;
  logic [3:0]           w_nxt_tens;
  logic [3:0]           w_nxt_ones;
  slot_t                w_next_slot;
  logic [7:0]           w_next_byte;
  logic [15:0]          w_digits;

  frame_tick_gen #(
    .PERIOD_CLKS(PERIOD_CLKS)
  ) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .o_tick(w_tick)
  );

  // Next enabled channel search. In IDLE it scans the live mask from channel
  // 0 (the snapshot is being taken on the same edge); in SEND it scans the
  // snapshot mask above the current channel. The decimal tens/ones pair is
  // carried along the scan as a BCD counter, so no divider is needed.
  always_comb begin : search
    logic [NCH-1:0] v_mask;
    int             v_first;
    logic [3:0]     v_tens;
    logic [3:0]     v_ones;
    v_mask      = (r_state == IDLE) ? ch_mask : r_snap_mask;
    v_first     = (r_state == IDLE) ? 0 : int'(r_ch) + 1;
    v_tens      = 4'd0;
    v_ones      = 4'd0;
    w_nxt_found = 1'b0;
    w_nxt_ch    = '0;
    w_nxt_tens  = 4'd0;
    w_nxt_ones  = 4'd0;
    for (int j = 0; j < NCH; j++) begin
      if (!w_nxt_found && v_mask[j] && (j >= v_first)) begin
        w_nxt_found = 1'b1;
        w_nxt_ch    = CH_W'(j);
        w_nxt_tens  = v_tens;
        w_nxt_ones  = v_ones;
      end
      if (v_ones == 4'd9) begin
        v_ones = 4'd0;
        v_tens = v_tens + 4'd1;
      end else begin
        v_ones = v_ones + 4'd1;
      end
    end
  end

  assign w_digits = r_snap_bcd[r_ch];

  // Slot sequencing; the single DOT slot is placed according to DP_POS.
  always_comb begin
    w_next_slot = r_slot;
    case (r_slot)
      SLOT_TENS:  w_next_slot = SLOT_ONES;
      SLOT_ONES:  w_next_slot = SLOT_COLON;
      SLOT_COLON: w_next_slot = SLOT_D3;
      SLOT_D3:    w_next_slot = (DP_POS == 3) ? SLOT_DOT : SLOT_D2;
      SLOT_DOT:   w_next_slot = (DP_POS == 3) ? SLOT_D2 :
                                (DP_POS == 2) ? SLOT_D1 : SLOT_D0;
      SLOT_D2:    w_next_slot = (DP_POS == 2) ? SLOT_DOT : SLOT_D1;
      SLOT_D1:    w_next_slot = (DP_POS == 1) ? SLOT_DOT : SLOT_D0;
      SLOT_D0:    w_next_slot = w_nxt_found ? SLOT_SEP : SLOT_CR;
      SLOT_SEP:   w_next_slot = SLOT_TENS;
      SLOT_CR:    w_next_slot = SLOT_LF;
      default:    w_next_slot = SLOT_LF;
    endcase
  end

  // Byte for the slot about to become current. TENS only follows SEP, where
  // the search result already names the upcoming channel.
  always_comb begin
    w_next_byte = 8'h00;
    case (w_next_slot)
      SLOT_TENS:  w_next_byte = c_ascii_zero + {4'h0, w_nxt_tens};
      SLOT_ONES:  w_next_byte = c_ascii_zero + {4'h0, r_ones};
      SLOT_COLON: w_next_byte = c_ascii_colon;
      SLOT_D3:    w_next_byte = bcd_to_ascii(w_digits[15:12]);
      SLOT_DOT:   w_next_byte = c_ascii_dot;
      SLOT_D2:    w_next_byte = bcd_to_ascii(w_digits[11:8]);
      SLOT_D1:    w_next_byte = bcd_to_ascii(w_digits[7:4]);
      SLOT_D0:    w_next_byte = bcd_to_ascii(w_digits[3:0]);
      SLOT_SEP:   w_next_byte = SEP;
      SLOT_CR:    w_next_byte = c_ascii_cr;
      SLOT_LF:    w_next_byte = c_ascii_lf;
      default:    w_next_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_slot      <= SLOT_TENS;
      r_ch        <= '0;
      r_tens      <= 4'd0;
      r_ones      <= 4'd0;
      r_snap_bcd  <= '0;
      r_snap_mask <= '0;
      r_data      <= 8'h00;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_tick && enable) begin
            r_snap_bcd  <= bcd_in;
            r_snap_mask <= ch_mask;
            r_state     <= SEND;
            r_busy      <= 1'b1;
            r_ch        <= w_nxt_ch;
            r_tens      <= w_nxt_tens;
            r_ones      <= w_nxt_ones;
            r_slot      <= w_nxt_found ? SLOT_TENS : SLOT_CR;
            r_data      <= w_nxt_found ? (c_ascii_zero + {4'h0, w_nxt_tens})
                                       : c_ascii_cr;
          end
        end
        SEND: begin
          // Everything advances only on an accepted byte; a full FIFO
          // simply freezes slot, channel and w_data.
          if (wr_uart) begin
            if (r_slot == SLOT_LF) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_slot <= w_next_slot;
              r_data <= w_next_byte;
              if (r_slot == SLOT_SEP) begin
                r_ch   <= w_nxt_ch;
                r_tens <= w_nxt_tens;
                r_ones <= w_nxt_ones;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Combinational strobe so a full FIFO blocks the write in the same cycle.
  assign wr_uart    = (r_state == SEND) && !tx_full;
  assign w_data     = r_data;
  assign busy       = r_busy;
  assign frame_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_uart_frame_sequencer                                     |
// | Purpose  : Scoreboard bench for uart_frame_sequencer, NCH=2, period    |
// |            100, one instance with DP_POS=3 and one with DP_POS=0.      |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
module tb_uart_frame_sequencer;

  localparam int PERIOD = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        tx_full;
  logic [1:0]  ch_mask;
  logic [31:0] bcd_in;

  logic        wr_a, busy_a, done_a;
  logic [7:0]  data_a;
  logic        wr_b, busy_b, done_b;
  logic [7:0]  data_b;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  // Expected stream per DUT; bit 8 set marks an expected frame_done pulse.
  logic [8:0]  q_a[$];
  logic [8:0]  q_b[$];

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  uart_frame_sequencer #(
    .NCH(2), .PERIOD_CLKS(PERIOD), .DP_POS(3), .SEP(8'h3B)
  ) u_dut_dp3 (
    .clk(clk), .rst(rst), .enable(enable), .ch_mask(ch_mask),
    .bcd_in(bcd_in), .tx_full(tx_full), .wr_uart(wr_a), .w_data(data_a),
    .busy(busy_a), .frame_done(done_a)
  );

  uart_frame_sequencer #(
    .NCH(2), .PERIOD_CLKS(PERIOD), .DP_POS(0), .SEP(8'h3B)
  ) u_dut_dp0 (
    .clk(clk), .rst(rst), .enable(enable), .ch_mask(ch_mask),
    .bcd_in(bcd_in), .tx_full(tx_full), .wr_uart(wr_b), .w_data(data_b),
    .busy(busy_b), .frame_done(done_b)
  );

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_str(input bit sel, input string s);
    for (int i = 0; i < s.len(); i++) begin
      if (sel) q_b.push_back({1'b0, s[i]});
      else     q_a.push_back({1'b0, s[i]});
    end
    if (sel) begin
      q_b.push_back(9'h00D); q_b.push_back(9'h00A); q_b.push_back(9'h100);
    end else begin
      q_a.push_back(9'h00D); q_a.push_back(9'h00A); q_a.push_back(9'h100);
    end
  endtask

  task automatic expect_frame(input string sa, input string sb);
    push_str(1'b0, sa);
    push_str(1'b1, sb);
  endtask

  task automatic check_write(input bit sel, input logic [7:0] got);
    logic [8:0] exp;
    checks++;
    if ((sel ? q_b.size() : q_a.size()) == 0) begin
      errors++;
      $display("FAIL byte_%s: got unexpected write %h, required no write", sel ? "dp0" : "dp3", got);
    end else begin
      exp = sel ? q_b.pop_front() : q_a.pop_front();
      if (exp[8] || exp[7:0] !== got) begin
        errors++;
        $display("FAIL byte_%s: got %h, required %s%h", sel ? "dp0" : "dp3", got,
                 exp[8] ? "frame_done before byte " : "", exp[7:0]);
      end
    end
  endtask

  task automatic check_done(input bit sel);
    logic [8:0] exp;
    checks++;
    if ((sel ? q_b.size() : q_a.size()) == 0) begin
      errors++;
      $display("FAIL done_%s: got unexpected frame_done, required none", sel ? "dp0" : "dp3");
    end else begin
      exp = sel ? q_b.pop_front() : q_a.pop_front();
      if (!exp[8]) begin
        errors++;
        $display("FAIL done_%s: got frame_done, required byte %h first", sel ? "dp0" : "dp3", exp[7:0]);
      end
    end
  endtask

  task automatic wait_busy(input string name);
    bit seen = 1'b0;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge clk);
      seen = busy_a;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_start: busy got 0 for 300 cycles, required 1", name);
    end
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int n = 0; n < 400 && !seen; n++) begin
      @(negedge clk);
      seen = done_a;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_done: frame_done got 0 for 400 cycles, required 1", name);
    end
  endtask

  task automatic stall(input int n, input bit perturb);
    logic [7:0] held;
    tx_full = 1'b1;
    held    = data_a;
    if (perturb) begin
      bcd_in  = 32'h9999_8888;
      ch_mask = 2'b01;
    end
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checks++;
      if (wr_a !== 1'b0 || data_a !== held) begin
        errors++;
        $display("FAIL stall: got wr_uart=%b w_data=%h, required wr_uart=0 w_data=%h", wr_a, data_a, held);
      end
      step();
    end
    tx_full = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every write / frame_done and checks
  // that each frame starts one cycle after a period tick, writing at once.
  initial begin : monitor
    bit prev_busy;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        if (wr_a)   check_write(1'b0, data_a);
        if (done_a) check_done(1'b0);
        if (wr_b)   check_write(1'b1, data_b);
        if (done_b) check_done(1'b1);
        if (busy_a && !prev_busy) begin
          checks++;
          if (cyc % PERIOD != 1) begin
            errors++;
            $display("FAIL frame_start: got start at cycle %0d, required cycle = 1 mod %0d", cyc, PERIOD);
          end
          checks++;
          if (wr_a !== 1'b1) begin
            errors++;
            $display("FAIL first_write: got wr_uart=%b, required 1", wr_a);
          end
        end
        prev_busy = busy_a;
      end else begin
        prev_busy = 1'b0;
      end
    end
  end

  initial begin : stimulus
    bit saw;
    rst     = 1'b1;
    enable  = 1'b1;
    tx_full = 1'b0;
    ch_mask = 2'b11;
    bcd_in  = 32'h0500_1234;
    #3 rst = 1'b0;
    step(); step(); step();
    expect_frame("00:1.234;01:0.500", "00:1234;01:0500");
    rst = 1'b1;

    // Quiet until the first tick.
    for (int i = 0; i < 99; i++) begin
      @(negedge clk);
      checks++;
      if (wr_a !== 1'b0 || data_a !== 8'h00 || busy_a !== 1'b0 || done_a !== 1'b0 ||
          wr_b !== 1'b0 || data_b !== 8'h00 || busy_b !== 1'b0 || done_b !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle: got wr=%b data=%h busy=%b done=%b, required all 0",
                 wr_a, data_a, busy_a, done_a);
      end
    end
    wait_busy("both"); wait_done("both");

    step(); ch_mask = 2'b10;
    expect_frame("01:0.500", "01:0500");
    wait_busy("mask10"); wait_done("mask10");

    step(); ch_mask = 2'b00;
    expect_frame("", "");
    wait_busy("mask00"); wait_done("mask00");

    step(); ch_mask = 2'b01; bcd_in = 32'h0500_12A4;
    expect_frame("00:1.2?4", "00:12?4");
    wait_busy("bad_digit"); wait_done("bad_digit");

    // Short stall with inputs changed mid-frame.
    step(); ch_mask = 2'b11; bcd_in = 32'h0500_1234;
    expect_frame("00:1.234;01:0.500", "00:1234;01:0500");
    wait_busy("stall5");
    repeat (6) step();
    stall(5, 1'b1);
    wait_done("stall5");

    // Stall longer than a period: the tick during busy must be dropped.
    step(); ch_mask = 2'b11; bcd_in = 32'h0500_1234;
    expect_frame("00:1.234;01:0.500", "00:1234;01:0500");
    wait_busy("stall130");
    repeat (6) step();
    stall(130, 1'b0);
    wait_done("stall130");

    // Reset mid-frame.
    step();
    expect_frame("00:1.234;01:0.500", "00:1234;01:0500");
    wait_busy("abort");
    repeat (4) step();
    rst = 1'b0;
    #1;
    checks++;
    if (wr_a !== 1'b0 || busy_a !== 1'b0 || data_a !== 8'h00 ||
        wr_b !== 1'b0 || busy_b !== 1'b0 || data_b !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: got wr=%b busy=%b data=%h, required 0 0 00", wr_a, busy_a, data_a);
    end
    q_a.delete();
    q_b.delete();
    step(); step();
    expect_frame("00:1.234;01:0.500", "00:1234;01:0500");
    rst = 1'b1;
    wait_busy("after_reset"); wait_done("after_reset");

    // Enable dropped mid-frame: frame completes, nothing follows.
    step();
    expect_frame("00:1.234;01:0.500", "00:1234;01:0500");
    wait_busy("disable");
    repeat (3) step();
    enable = 1'b0;
    wait_done("disable");
    saw = 1'b0;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      if (busy_a || busy_b) saw = 1'b1;
    end
    checks++;
    if (saw) begin
      errors++;
      $display("FAIL disabled: got busy=1 after enable=0, required no new frame");
    end

    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d/%0d pending expectations, required 0/0", q_a.size(), q_b.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_frame_sequencer.md
Name: uart_frame_sequencer

Overview:
Parametrised successor to the fixed 13-channel UART reporter. Runs on the 65 MHz clock domain. Periodically snapshots NCH packed 4-digit BCD channel readings and serialises them as one ASCII text frame, one byte per accepted write. Writes go into the existing UART TX FIFO (wr_uart/w_data/tx_full). Adds over the previous block: channel count, decimal-point position, frame rate and separator parameters; per-channel mask; frame-start snapshot; back-pressure; invalid-digit flagging.

Parameters:
NCH, 13, number of channels (1..99).
PERIOD_CLKS, 65_000_000, clocks between frame starts (>= 2).
DP_POS, 3, digits after the decimal point (0..3; 0 = no point emitted).
SEP, 8'h3B, separator byte between channels (';').

Ports:
clk  in  1  system clock (65 MHz).
rst  in  1  asynchronous, active-low reset (rst=0 resets).
enable  in  1  frame generation enable.
ch_mask  in  NCH  1 = channel included in frame.
bcd_in  in  16*NCH  channel i at bits [16i+15:16i]; digit3 is the MS nibble.
tx_full  in  1  UART FIFO full.
wr_uart  out  1  byte write strobe.
w_data  out  8  ASCII byte.
busy  out  1  frame in progress.
frame_done  out  1  one-cycle pulse after the last byte (LF) is written.

Behaviour:
- Reset (async assert, sync release) clears:
  - outputs: wr_uart=0, w_data=0, busy=0, frame_done=0;
  - state: IDLE; period counter=0; snapshot registers=0.
- Period counter runs freely 0..PERIOD_CLKS-1 and wraps. tick=1 on the wrap cycle. The counter runs regardless of enable.
- State IDLE: on tick && enable:
  - latch bcd_in and ch_mask into snapshot registers;
  - set channel index to the first channel with its mask bit set; go to SEND.
  - If no mask bit is set, go directly to the CR/LF part of SEND.
- Per enabled channel i, byte sequence (8 bytes, or 7 when DP_POS=0):
  - tens('0'+i/10), ones('0'+i%10), ':', then 4 digits MS first;
  - '.' inserted before the last DP_POS digits.
  - Example: 16'h1234 with DP_POS=3 gives "1.234".
- SEP is emitted between consecutive enabled channels, never after the last one. Frame ends with CR (0x0D) then LF (0x0A).
- Digit value > 9 is emitted as '?' (0x3F).
- Channel index is held as a separate tens/ones decimal counter pair. No division hardware.
- Handshake:
  - w_data is a registered current byte; wr_uart = (state==SEND) && !tx_full, combinational.
  - The byte pointer advances only on a cycle with wr_uart=1.
  - tx_full=1 stalls with w_data held stable.
  - No byte is ever dropped or duplicated.
- Latency: tick at edge t means snapshot at edge t+1, and the first wr_uart is possible in the cycle after edge t+1.
- After LF is accepted: frame_done=1 for one cycle, busy=0, return to IDLE.
- busy=1 for the entire SEND state.
- Simultaneous events:
  - tick while busy is dropped; no queuing.
  - enable deassertion mid-frame completes the current frame; no further frames start.
  - bcd_in/ch_mask changes mid-frame have no effect until the next snapshot.
- Reset asserted mid-frame aborts immediately. No partial-frame recovery.

Decomposition:
- Package uart_frame_pkg holds:
  - ASCII constants (ZERO, COLON, DOT, QMARK, CR, LF);
  - state enum {IDLE, SEND};
  - byte-slot enum {TENS, ONES, COLON, D3, DOT, D2, D1, D0, SEP, CR, LF};
  - helper function bcd_to_ascii (nibble -> '0'..'9' or '?').
- Sub-module frame_tick_gen: the parametrised period counter producing tick.

Test Plan:
- Reset release with tx_full=0 -> zero outputs until the first tick.
- NCH=2, PERIOD_CLKS=100, mask=2'b11, ch0=16'h1234, ch1=16'h0500, DP_POS=3 -> bytes "00:1.234;01:0.500\r\n" (19 writes), then one frame_done pulse.
- Same setup, mask=2'b10 -> "01:0.500\r\n". Mask=0 -> "\r\n" only.
- ch0=16'h12A4 -> "00:1.2?4".
- DP_POS=0 -> "00:1234".
- tx_full held 1 for 5 cycles mid-frame -> wr_uart=0 and w_data stable throughout; byte stream identical to the unstalled case.
- bcd_in changed during SEND -> the frame carries the old values. A tick during busy yields no second frame start; the next frame starts on the following tick.
- rst=0 mid-frame -> wr_uart/busy drop asynchronously. After release, the next frame starts cleanly at channel 00.
